fir_shared_mac_ch: RTL and testbench
====================================

// Module: fir_shared_mac_ch
// PURPOSE
//  Parametrised single-MAC (resource-shared) FIR filter with one time-shared multiplier.
//  - Next generation of the team's shared-MAC FIR: adds valid/ready handshakes, run-time
//    loadable coefficients, parametrised widths/taps, and rounding with saturation.
//  - Sits between the sample source and the downstream decimator/DAC path.
//  - Accepts one sample per computation, runs TAPS (or folded) MAC cycles, then holds the result.
// PARAMETERS
//  DATA_W    16  signed input/output sample width
//  COEF_W    16  signed coefficient width
//  TAPS      19  number of filter taps (>=2)
//  OUT_SHIFT 15  arithmetic right shift applied to accumulator before output
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  in_valid     in   1        in_data valid
//  in_ready     out  1        block can accept a sample (IDLE only)
//  in_data      in   DATA_W   signed sample
//  out_valid    out  1        out_data valid, held until out_ready
//  out_ready    in   1        downstream accepts out_data
//  out_data     out  DATA_W   signed filtered sample (rounded, saturated)
//  out_sat      out  1        out_data was clipped; qualified by out_valid
//  coef_wr_en   in   1        coefficient write strobe
//  coef_wr_addr in   clog2(TAPS)  coefficient index
//  coef_wr_data in   COEF_W   signed coefficient value
//  coef_wr_err  out  1        one-cycle pulse: write rejected (busy or addr out of range)
// BEHAVIOUR
//  - Reset: delay line, coefficients, and accumulator = 0. State = IDLE.
//    in_ready=1; out_valid=0; out_data=0; out_sat=0; coef_wr_err=0.
//  - FSM IDLE -> MAC -> OUT -> IDLE.
//    IDLE: in_ready=1. When in_valid&in_ready: x[0]<=in_data, x[k+1]<=x[k], acc<=0, idx<=0, go MAC.
//    MAC: in_ready=0. Each cycle acc += term(idx); idx++. After N cycles go OUT.
//      N=TAPS (unfolded) or ceil(TAPS/2) (folded).
//      term(k)=x[k]*c[k] (unfolded).
//    OUT: out_valid=1 with registered result. out_valid rises N+1 clocks after the accept edge.
//      On out_valid&out_ready go IDLE. in_ready=1 in the following cycle.
//  - Throughput: one sample per N+2 cycles when out_ready is held high.
//  - Widths:
//    product: full precision (DATA_W+COEF_W, +1 when folded).
//    ACC_W = product width + clog2(TAPS); no internal overflow is possible.
//  - Output: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up).
//    Clip r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 if clipped.
//  - Coefficients: a write is accepted only in IDLE and only when addr < number of stored coefs.
//    Otherwise the write is ignored and coef_wr_err pulses the next cycle.
//    - Write coincident with a sample accept: the write takes effect and the new value is used
//      by that computation.
//  - in_valid while busy: no accept; source must hold data (standard valid/ready).
//  - Reset mid-MAC or mid-OUT: immediate return to reset state. Partial result discarded.
// CONFIGURATION
//  SYMMETRIC_FOLD_EN defined:
//    - Coefficients are symmetric. Only ceil(TAPS/2) are stored; valid addr range is 0..ceil(TAPS/2)-1.
//    - term(k) = (x[k] + x[TAPS-1-k]) * c[k], with a DATA_W+1 pre-add.
//    - For odd TAPS, the middle tap uses x[mid] alone, not doubled.
//    - N = ceil(TAPS/2).
//  SYMMETRIC_FOLD_EN undefined:
//    - TAPS coefficients stored; valid addr range is 0..TAPS-1.
//    - No pre-adder. N = TAPS.
// TESTING
//  1 Reset: assert reset mid-MAC -> out_valid=0, in_ready=1 asynchronously. Next output uses a zeroed delay line.
//  2 Impulse, all coefs=16384, OUT_SHIFT=15: input 1000 then 0s -> 19 outputs of 500, then 0.
//    Checks: out_valid at accept+N+1; folded N=10, unfolded N=19.
//  3 Saturation: coefs=32767, 19 samples of 32767 -> out_data=32767, out_sat=1.
//    Same with -32768 -> out_data=-32768, out_sat=1.
//  4 Backpressure: out_ready=0 for 7 cycles -> out_valid and out_data stable, in_ready=0.
//    A sample offered meanwhile is accepted only after out_ready=1.
//  5 Coef write in MAC state -> coef_wr_err pulse, coefficient unchanged.
//    Write addr=TAPS (unfolded) or addr=10 (folded) -> coef_wr_err pulse.
//  6 Rounding: single coef[0]=1, input 16384 -> out_data=1 (round half up).
//    Input 16383 -> out_data=0.

Source files
------------

// File: rtl/fir_shared_mac_ch.sv
`timescale 1ns/1ps
// Single-multiplier FIR: one sample in, N MAC cycles, one rounded/saturated sample out.
// Define SYMMETRIC_FOLD_EN for the symmetric-coefficient variant with a pre-adder.
module fir_shared_mac_ch #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int TAPS      = 19,
   parameter int OUT_SHIFT = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  out_data,
   output logic                      out_sat,
   input  logic                      coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
   input  logic signed [COEF_W-1:0]  coef_wr_data,
   output logic                      coef_wr_err,
   output logic [1:0]                o_dbg_state
);

   // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
   // valid never depends on ready, and the data is held stable until that edge.

   localparam int ADDR_W = $clog2(TAPS);
`ifdef SYMMETRIC_FOLD_EN
   localparam int NCOEF  = (TAPS + 1) / 2;
   localparam int PRE_W  = DATA_W + 1;
`else
   localparam int NCOEF  = TAPS;
   localparam int PRE_W  = DATA_W;
`endif
   localparam int PROD_W = PRE_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(TAPS);
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [ADDR_W-1:0]      LAST_IDX = ADDR_W'(NCOEF - 1);
   localparam logic signed [SUM_W-1:0] RND =
      (OUT_SHIFT > 0) ? (SUM_W'(1) <<< (OUT_SHIFT - 1)) : '0;
   localparam logic signed [SUM_W-1:0] MAX_V =
      SUM_W'((longint'(1) <<< (DATA_W - 1)) - longint'(1));
   localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                   r_state;
   logic signed [DATA_W-1:0] r_x [TAPS];
   logic signed [COEF_W-1:0] r_c [NCOEF];
   logic [ADDR_W-1:0]        r_idx;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic signed [DATA_W-1:0] r_out_data;
   logic                     r_out_sat;
   logic                     r_wr_err;

   logic signed [DATA_W-1:0] w_x_a;
   logic signed [COEF_W-1:0] w_c;
   logic signed [PRE_W-1:0]  w_pre;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [SUM_W-1:0]  w_shr;
   logic                     w_sat_hi;
   logic                     w_sat_lo;
   logic signed [DATA_W-1:0] w_res;
   logic                     w_wr_ok;

   always_comb begin
      w_x_a = '0;
      w_c   = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (r_idx == ADDR_W'(k)) w_x_a = r_x[k];
      end
      for (int k = 0; k < NCOEF; k++) begin
         if (r_idx == ADDR_W'(k)) w_c = r_c[k];
      end
   end

`ifdef SYMMETRIC_FOLD_EN
   localparam logic [ADDR_W-1:0] MID_IDX  = ADDR_W'((TAPS - 1) / 2);
   localparam bit                TAPS_ODD = (TAPS % 2) == 1;
   logic signed [DATA_W-1:0] w_x_b;

   always_comb begin
      w_x_b = '0;
      w_pre = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (r_idx == ADDR_W'(TAPS - 1 - k)) w_x_b = r_x[k];
      end
      // The centre tap of an odd-length filter pairs with itself and is not doubled.
      if (TAPS_ODD && (r_idx == MID_IDX)) w_pre = PRE_W'(w_x_a);
      else                               w_pre = PRE_W'(w_x_a) + PRE_W'(w_x_b);
   end
`else
   assign w_pre = w_x_a;
`endif

   assign w_prod     = PROD_W'(w_pre) * PROD_W'(w_c);
   assign w_acc_next = r_acc + ACC_W'(w_prod);

   // Round half up, then clip; computed from the final accumulation in the last MAC cycle.
   assign w_sum    = SUM_W'(w_acc_next) + RND;
   assign w_shr    = w_sum >>> OUT_SHIFT;
   assign w_sat_hi = w_shr > MAX_V;
   assign w_sat_lo = w_shr < MIN_V;
   assign w_res    = w_sat_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                     w_sat_lo ? {1'b1, {(DATA_W-1){1'b0}}} :
                                w_shr[DATA_W-1:0];

   assign w_wr_ok = coef_wr_en && (r_state == S_IDLE) && (int'(coef_wr_addr) < NCOEF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_wr_err    <= 1'b0;
         for (int k = 0; k < TAPS; k++)  r_x[k] <= '0;
         for (int k = 0; k < NCOEF; k++) r_c[k] <= '0;
      end else begin
         r_wr_err <= coef_wr_en && !w_wr_ok;
         // A write on the accept edge lands before the first MAC cycle reads it.
         for (int k = 0; k < NCOEF; k++) begin
            if (w_wr_ok && (coef_wr_addr == ADDR_W'(k))) r_c[k] <= coef_wr_data;
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
                  r_x[0]     <= in_data;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + ADDR_W'(1);
               if (r_idx == LAST_IDX) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_res;
                  r_out_sat   <= w_sat_hi || w_sat_lo;
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_sat     = r_out_sat;
   assign coef_wr_err = r_wr_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fir_shared_mac_ch.sv
`timescale 1ns/1ps
// Bench for fir_shared_mac_ch: randomized and directed samples against a direct-form FIR model.
module tb_fir_shared_mac_ch;

   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int TAPS  = 19;
   localparam int OSH   = 15;
   localparam int AW    = $clog2(TAPS);
`ifdef SYMMETRIC_FOLD_EN
   localparam int NC    = (TAPS + 1) / 2;
`else
   localparam int NC    = TAPS;
`endif
   localparam int N     = NC;
   localparam int CLK_P = 10;
   localparam int TMO   = 200;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;
   logic                 out_sat;
   logic                 coef_wr_en;
   logic [AW-1:0]        coef_wr_addr;
   logic signed [CW-1:0] coef_wr_data;
   logic                 coef_wr_err;
   logic [1:0]           dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   longint     hist [TAPS];
   longint     cf   [TAPS];
   logic [DW:0] exp_q[$];

   fir_shared_mac_ch #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_SHIFT(OSH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .coef_wr_err(coef_wr_err), .o_dbg_state(dbg_state)
   );

   always #(CLK_P/2) clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model: y = sum x[n-j]*h[j], round half up, clip
   function automatic void model_reset();
      for (int k = 0; k < TAPS; k++) begin
         hist[k] = 0;
         cf[k]   = 0;
      end
      exp_q.delete();
   endfunction

   function automatic void model_coef(input int a, input longint v);
`ifdef SYMMETRIC_FOLD_EN
      cf[a]          = v;
      cf[TAPS-1-a]   = v;
`else
      cf[a]          = v;
`endif
   endfunction

   function automatic logic [DW:0] model_eval();
      longint acc  = 0;
      longint r;
      longint maxv = (longint'(1) <<< (DW - 1)) - 1;
      longint minv = -(longint'(1) <<< (DW - 1));
      logic   sat  = 1'b0;
      for (int k = 0; k < TAPS; k++) acc += hist[k] * cf[k];
      r = (acc + (longint'(1) <<< (OSH - 1))) >>> OSH;
      if (r > maxv) begin
         r = maxv; sat = 1'b1;
      end else if (r < minv) begin
         r = minv; sat = 1'b1;
      end
      return {sat, r[DW-1:0]};
   endfunction

   function automatic void model_push(input int x);
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      exp_q.push_back(model_eval());
   endfunction

   // ---------------- drivers (called at #1 after a rising edge)
   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic write_coef(input int a, input int v);
      coef_wr_en   = 1'b1;
      coef_wr_addr = AW'(a);
      coef_wr_data = CW'(v);
      @(posedge clk); #1;
      coef_wr_en   = 1'b0;
      if (a < NC) model_coef(a, v);
   endtask

   task automatic accept_sample(input int x, output time t, output bit to);
      int c = 0;
      in_valid = 1'b1;
      in_data  = DW'(x);
      while (!in_ready && c < TMO) begin
         @(posedge clk); #1; c++;
      end
      to = !in_ready;
      t  = 0;
      if (!to) begin
         @(posedge clk);
         t = $time;
         #1;
         model_push(x);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output bit to);
      lat = 0;
      while (!out_valid && lat < TMO) begin
         @(posedge clk); #1; lat++;
      end
      to = !out_valid;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_sample(input int x, output logic [DW:0] got, output logic [DW:0] e,
                            output int lat, output time t, output bit to);
      bit to_a, to_v;
      got = '0; e = '1; lat = 0;
      accept_sample(x, t, to_a);
      to = to_a;
      if (!to_a) begin
         wait_valid(lat, to_v);
         got = {out_sat, out_data};
         e   = exp_q.pop_front();
         release_out();
         to  = to_v;
      end
   endtask

   // ---------------- tests
   task automatic test_reset();
      time t; bit to; int lat;
      logic [DW:0] got, e;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0 ||
          coef_wr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_sat=%b err=%b, want 1 0 0 0 0",
                  in_ready, out_valid, out_data, out_sat, coef_wr_err);
      end
      reset = 1'b0;
      model_reset();
      for (int a = 0; a < NC; a++) write_coef(a, 100);
      accept_sample(1234, t, to);
      n_cmp++;
      if (to) begin
         n_fail++; $display("FAIL reset_accept: timeout, want accept");
      end
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_async: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      for (int a = 0; a < NC; a++) write_coef(a, 100);
      do_sample(777, got, e, lat, t, to);
      n_cmp++;
      if (to || got !== e) begin
         n_fail++;
         $display("FAIL reset_zeroed_line: got sat=%b data=%0d, want sat=%b data=%0d (to=%b)",
                  got[DW], $signed(got[DW-1:0]), e[DW], $signed(e[DW-1:0]), to);
      end
   endtask

   task automatic test_impulse();
      time t; bit to; int lat;
      logic [DW:0] got, e;
      logic signed [DW-1:0] want;
      apply_reset();
      for (int a = 0; a < NC; a++) write_coef(a, 16384);
      for (int i = 0; i < TAPS + 1; i++) begin
         do_sample((i == 0) ? 1000 : 0, got, e, lat, t, to);
         want = (i < TAPS) ? 16'sd500 : 16'sd0;
         n_cmp++;
         if (to || got !== e || got[DW-1:0] !== want || got[DW] !== 1'b0) begin
            n_fail++;
            $display("FAIL impulse[%0d]: got sat=%b data=%0d, want sat=0 data=%0d (to=%b)",
                     i, got[DW], $signed(got[DW-1:0]), want, to);
         end
         n_cmp++;
         if (lat !== N) begin
            n_fail++;
            $display("FAIL impulse_latency[%0d]: valid seen at accept+%0d, want accept+%0d",
                     i, lat + 1, N + 1);
         end
      end
   endtask

   task automatic test_saturation();
      time t; bit to; int lat;
      logic [DW:0] got, e;
      apply_reset();
      for (int a = 0; a < NC; a++) write_coef(a, 32767);
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < TAPS; i++) begin
            do_sample((p == 0) ? 32767 : -32768, got, e, lat, t, to);
            n_cmp++;
            if (to || got !== e) begin
               n_fail++;
               $display("FAIL saturation[%0d][%0d]: got sat=%b data=%0d, want sat=%b data=%0d",
                        p, i, got[DW], $signed(got[DW-1:0]), e[DW], $signed(e[DW-1:0]));
            end
         end
         n_cmp++;
         if (got !== ((p == 0) ? 17'h17fff : 17'h18000)) begin
            n_fail++;
            $display("FAIL saturation_final[%0d]: got sat=%b data=%0d, want sat=1 data=%0d",
                     p, got[DW], $signed(got[DW-1:0]), (p == 0) ? 32767 : -32768);
         end
      end
   endtask

   task automatic test_backpressure();
      time t; bit to, to2; int lat;
      logic [DW:0] got, e;
      apply_reset();
      for (int a = 0; a < NC; a++) write_coef(a, 1000 + 37 * a);
      out_ready = 1'b0;
      accept_sample(500, t, to);
      wait_valid(lat, to2);
      n_cmp++;
      if (to || to2) begin
         n_fail++; $display("FAIL backpressure_first: timeout accept=%b valid=%b", to, to2);
      end else begin
         e = exp_q.pop_front();
         in_valid = 1'b1;
         in_data  = -16'sd1234;
         for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || {out_sat, out_data} !== e || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL backpressure_hold[%0d]: valid=%b data=%0d in_ready=%b, want 1 %0d 0",
                        i, out_valid, out_data, in_ready, $signed(e[DW-1:0]));
            end
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
         end
         do_sample(-1234, got, e, lat, t, to);
         n_cmp++;
         if (to || got !== e || lat !== N) begin
            n_fail++;
            $display("FAIL backpressure_next: got data=%0d lat=%0d, want data=%0d lat=%0d",
                     $signed(got[DW-1:0]), lat, $signed(e[DW-1:0]), N);
         end
      end
   endtask

   task automatic test_coef_err();
      time t; bit to, to2; int lat;
      logic [DW:0] got, e;
      accept_sample(321, t, to);
      @(posedge clk); #1;
      coef_wr_en   = 1'b1;
      coef_wr_addr = '0;
      coef_wr_data = -16'sd5000;
      @(posedge clk); #1;
      coef_wr_en   = 1'b0;
      n_cmp++;
      if (coef_wr_err !== 1'b1) begin
         n_fail++; $display("FAIL coef_err_busy: err=%b, want 1", coef_wr_err);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (coef_wr_err !== 1'b0) begin
         n_fail++; $display("FAIL coef_err_pulse: err=%b, want 0", coef_wr_err);
      end
      wait_valid(lat, to2);
      n_cmp++;
      if (to || to2) begin
         n_fail++; $display("FAIL coef_err_busy_result: timeout accept=%b valid=%b", to, to2);
      end else begin
         got = {out_sat, out_data};
         e   = exp_q.pop_front();
         if (got !== e) begin
            n_fail++;
            $display("FAIL coef_err_busy_result: got %0d, want %0d",
                     $signed(got[DW-1:0]), $signed(e[DW-1:0]));
         end
         release_out();
      end
      write_coef(NC, 999);
      n_cmp++;
      if (coef_wr_err !== 1'b1) begin
         n_fail++; $display("FAIL coef_err_range: err=%b, want 1", coef_wr_err);
      end
      write_coef(NC - 1, 222);
      n_cmp++;
      if (coef_wr_err !== 1'b0) begin
         n_fail++; $display("FAIL coef_ok_no_err: err=%b, want 0", coef_wr_err);
      end
      do_sample(4321, got, e, lat, t, to);
      n_cmp++;
      if (to || got !== e) begin
         n_fail++;
         $display("FAIL coef_after_writes: got %0d, want %0d",
                  $signed(got[DW-1:0]), $signed(e[DW-1:0]));
      end
   endtask

   task automatic test_rounding();
      time t; bit to; int lat;
      logic [DW:0] got, e;
      apply_reset();
      in_valid     = 1'b1;
      in_data      = 16'sd16384;
      coef_wr_en   = 1'b1;
      coef_wr_addr = '0;
      coef_wr_data = 16'sd1;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      coef_wr_en = 1'b0;
      model_coef(0, 1);
      model_push(16384);
      n_cmp++;
      if (coef_wr_err !== 1'b0) begin
         n_fail++; $display("FAIL rounding_coincident_err: err=%b, want 0", coef_wr_err);
      end
      wait_valid(lat, to);
      got = {out_sat, out_data};
      e   = exp_q.pop_front();
      n_cmp++;
      if (to || got !== e || got !== 17'h00001) begin
         n_fail++;
         $display("FAIL rounding_half_up: got %0d, want 1", $signed(got[DW-1:0]));
      end
      release_out();
      do_sample(16383, got, e, lat, t, to);
      n_cmp++;
      if (to || got !== e || got !== 17'h00000) begin
         n_fail++;
         $display("FAIL rounding_below_half: got %0d, want 0", $signed(got[DW-1:0]));
      end
   endtask

   task automatic test_random();
      time t; bit to, to2; int lat, d, a, v;
      logic [DW:0] got, e;
      for (int k = 0; k < NC; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(0, 2 ** AW - 1));
            v = int'($urandom_range(0, 65535)) - 32768;
            write_coef(a, v);
            n_cmp++;
            if (coef_wr_err !== ((a >= NC) ? 1'b1 : 1'b0)) begin
               n_fail++;
               $display("FAIL random_wr_err[%0d]: addr=%0d err=%b, want %b", i, a, coef_wr_err, a >= NC);
            end
         end
         d = int'($urandom_range(0, 3));
         out_ready = (d == 0);
         accept_sample(int'($urandom_range(0, 65535)) - 32768, t, to);
         wait_valid(lat, to2);
         n_cmp++;
         if (to || to2) begin
            n_fail++; $display("FAIL random_timeout[%0d]: accept=%b valid=%b", i, to, to2);
         end else begin
            repeat (d) begin
               @(posedge clk); #1;
            end
            got = {out_sat, out_data};
            e   = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL random[%0d]: got sat=%b data=%0d, want sat=%b data=%0d",
                        i, got[DW], $signed(got[DW-1:0]), e[DW], $signed(e[DW-1:0]));
            end
            release_out();
         end
      end
   endtask

   task automatic test_back_to_back();
      time t, t_prev; bit to; int lat;
      logic [DW:0] got, e;
      out_ready = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 6; i++) begin
         do_sample(int'($urandom_range(0, 65535)) - 32768, got, e, lat, t, to);
         n_cmp++;
         if (to || got !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got %0d, want %0d",
                     i, $signed(got[DW-1:0]), $signed(e[DW-1:0]));
         end
         if (i > 0) begin
            n_cmp++;
            if (t - t_prev !== time'((N + 2) * CLK_P)) begin
               n_fail++;
               $display("FAIL back_to_back_period[%0d]: %0d ns, want %0d ns",
                        i, t - t_prev, (N + 2) * CLK_P);
            end
         end
         t_prev = t;
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_saturation();
      test_backpressure();
      test_coef_err();
      test_rounding();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
